// File: rtl/seg7_matrix_capture_if.sv
// Bus between a seven-segment beat source / frame consumer and seg7_matrix_capture.
//   seg_in, digit_sel, seg_valid, seg_ready : segment beat handshake
//   flush                                   : discard partially collected frame
//   out_valid, out_ready                    : rebuilt frame handshake
//   matrix_c, err_invalid, err_blank        : rebuilt frame and its error marks
//   frame_cnt                               : count of delivered frames
// master: the testbench / system side; slave: the capture block.
interface seg7_matrix_capture_if;
    logic [6:0]  seg_in;
    logic [1:0]  digit_sel;
    logic        seg_valid;
    logic        seg_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] matrix_c;
    logic        err_invalid;
    logic        err_blank;
    logic [7:0]  frame_cnt;

    modport master (
        output seg_in, digit_sel, seg_valid, flush, out_ready,
        input  seg_ready, out_valid, matrix_c, err_invalid, err_blank, frame_cnt
    );

    modport slave (
        input  seg_in, digit_sel, seg_valid, flush, out_ready,
        output seg_ready, out_valid, matrix_c, err_invalid, err_blank, frame_cnt
    );
endinterface

// File: rtl/seg7_matrix_capture.sv
// Rebuilds a 16-bit matrix from four seven-segment digit beats.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   ena   : global enable; 0 freezes all state
//   bus   : beat input handshake, flush, frame output handshake, error marks, frame counter
// Beats are decoded into nibbles and staged per digit; once all four digits have been seen
// the frame is published on matrix_c and held until the consumer takes it.
module seg7_matrix_capture (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    seg7_matrix_capture_if.slave        bus
);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] stage_q, stage_d;
    logic        st_inv_q, st_inv_d;
    logic        st_blank_q, st_blank_d;
    logic [15:0] matrix_q, matrix_d;
    logic        err_inv_q, err_inv_d;
    logic        err_blank_q, err_blank_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0]  nib;
    logic        beat_inv;
    logic        beat_blank;
    logic [3:0]  mask_new;
    logic [15:0] stage_new;
    logic        in_collect;
    logic        flush_take;
    logic        beat_take;
    logic        frame_done;
    logic        hs_take;

    // Segment pattern decode
    always_comb begin
        nib        = 4'h0;
        beat_inv   = 1'b0;
        beat_blank = 1'b0;
        case (bus.seg_in)
            7'h3F:   nib = 4'd0;
            7'h06:   nib = 4'd1;
            7'h5B:   nib = 4'd2;
            7'h4F:   nib = 4'd3;
            7'h66:   nib = 4'd4;
            7'h6D:   nib = 4'd5;
            7'h7D:   nib = 4'd6;
            7'h07:   nib = 4'd7;
            7'h7F:   nib = 4'd8;
            7'h00: begin
                nib        = 4'hF;
                beat_blank = 1'b1;
            end
            default: beat_inv = 1'b1;
        endcase
    end

    // Digit placement within the matrix
    always_comb begin
        stage_new = stage_q;
        case (bus.digit_sel)
            2'd0:    stage_new[11:8]  = nib;
            2'd1:    stage_new[15:12] = nib;
            2'd2:    stage_new[3:0]   = nib;
            default: stage_new[7:4]   = nib;
        endcase
    end

    assign in_collect = (state_q == StCollect);
    assign mask_new   = mask_q | (4'b0001 << bus.digit_sel);
    assign flush_take = ena && in_collect && bus.flush;
    // Flush has priority over a beat in the same cycle
    assign beat_take  = ena && in_collect && bus.seg_valid && !bus.flush;
    assign frame_done = beat_take && (mask_new == 4'hF);
    assign hs_take    = ena && (state_q == StHold) && bus.out_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StCollect: if (frame_done) state_d = StHold;
            StHold:    if (hs_take)    state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    // FSM outputs: decoded from state only
    always_comb begin
        bus.seg_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            StCollect: bus.seg_ready = 1'b1;
            StHold:    bus.out_valid = 1'b1;
            default:   bus.seg_ready = 1'b0;
        endcase
    end

    // Datapath next state
    always_comb begin
        mask_d      = mask_q;
        stage_d     = stage_q;
        st_inv_d    = st_inv_q;
        st_blank_d  = st_blank_q;
        matrix_d    = matrix_q;
        err_inv_d   = err_inv_q;
        err_blank_d = err_blank_q;
        cnt_d       = cnt_q;
        if (flush_take) begin
            mask_d     = 4'h0;
            stage_d    = 16'h0000;
            st_inv_d   = 1'b0;
            st_blank_d = 1'b0;
        end else if (beat_take) begin
            mask_d     = mask_new;
            stage_d    = stage_new;
            // Marks accumulate: an overwriting beat cannot clear an earlier mark
            st_inv_d   = st_inv_q | beat_inv;
            st_blank_d = st_blank_q | beat_blank;
            if (frame_done) begin
                matrix_d    = stage_new;
                err_inv_d   = st_inv_q | beat_inv;
                err_blank_d = st_blank_q | beat_blank;
            end
        end
        if (hs_take) begin
            mask_d     = 4'h0;
            st_inv_d   = 1'b0;
            st_blank_d = 1'b0;
            cnt_d      = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= 4'h0;
            stage_q     <= 16'h0000;
            st_inv_q    <= 1'b0;
            st_blank_q  <= 1'b0;
            matrix_q    <= 16'h0000;
            err_inv_q   <= 1'b0;
            err_blank_q <= 1'b0;
            cnt_q       <= 8'h00;
        end else begin
            mask_q      <= mask_d;
            stage_q     <= stage_d;
            st_inv_q    <= st_inv_d;
            st_blank_q  <= st_blank_d;
            matrix_q    <= matrix_d;
            err_inv_q   <= err_inv_d;
            err_blank_q <= err_blank_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.matrix_c    = matrix_q;
    assign bus.err_invalid = err_inv_q;
    assign bus.err_blank   = err_blank_q;
    assign bus.frame_cnt   = cnt_q;

endmodule

// File: tb/tb_seg7_matrix_capture.sv
// Randomized and directed bench for seg7_matrix_capture with a queue-based scoreboard.
module tb_seg7_matrix_capture;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    seg7_matrix_capture_if bus ();

    seg7_matrix_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] m;
        logic        inv;
        logic        blank;
    } frame_t;

    frame_t q[$];

    int errors = 0;
    int checks = 0;

    logic [6:0] pats [9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};

    // Reference model state
    logic [3:0]  vals [4];
    bit          got [4];
    bit          m_inv, m_blank;
    bit          exp_hold;
    logic [7:0]  exp_cnt;
    logic [15:0] last_m;
    bit          last_inv, last_blank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void dec(input logic [6:0] p, output logic [3:0] v,
                                output bit inv, output bit blank);
        v = 4'h0;
        inv = 0;
        blank = 0;
        if (p == 7'h00) begin
            v = 4'hF;
            blank = 1;
            return;
        end
        for (int i = 0; i < 9; i++) begin
            if (pats[i] == p) begin
                v = 4'(i);
                return;
            end
        end
        inv = 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            vals[i] = 4'h0;
            got[i]  = 0;
        end
        m_inv = 0;
        m_blank = 0;
        exp_hold = 0;
        exp_cnt = 8'h00;
        last_m = 16'h0000;
        last_inv = 0;
        last_blank = 0;
        q.delete();
    endtask

    // What the upcoming/current rising edge does, from the rules alone
    task automatic model_step();
        logic [3:0] v;
        bit inv, blank;
        frame_t f;
        if (!rst_n || !ena) return;
        if (exp_hold) begin
            if (bus.out_ready) begin
                exp_hold = 0;
                for (int i = 0; i < 4; i++) got[i] = 0;
                m_inv = 0;
                m_blank = 0;
                exp_cnt = exp_cnt + 8'd1;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < 4; i++) begin
                got[i]  = 0;
                vals[i] = 4'h0;
            end
            m_inv = 0;
            m_blank = 0;
        end else if (bus.seg_valid) begin
            dec(bus.seg_in, v, inv, blank);
            vals[bus.digit_sel] = v;
            got[bus.digit_sel]  = 1;
            m_inv   = m_inv | inv;
            m_blank = m_blank | blank;
            if (got[0] && got[1] && got[2] && got[3]) begin
                // element1 -> [11:8], element2 -> [15:12], element3 -> [3:0], element4 -> [7:4]
                f.m     = {vals[1], vals[0], vals[3], vals[2]};
                f.inv   = m_inv;
                f.blank = m_blank;
                q.push_back(f);
                last_m     = f.m;
                last_inv   = f.inv;
                last_blank = f.blank;
                exp_hold   = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic beat(input logic [1:0] d, input logic [6:0] p);
        bus.seg_valid = 1'b1;
        bus.digit_sel = d;
        bus.seg_in    = p;
        tick();
        bus.seg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [6:0] rand_pat();
        int r;
        r = $urandom_range(0, 11);
        if (r < 9) return pats[r];
        if (r == 9) return 7'h00;
        return 7'($urandom_range(0, 127));
    endfunction

    // Monitor: compares DUT outputs against the scoreboard on the falling edge
    always @(negedge clk) begin
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_hold});
        chk("seg_ready", {31'd0, bus.seg_ready}, {31'd0, !exp_hold});
        chk("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, exp_cnt});
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                chk("frame_matrix", {16'd0, bus.matrix_c}, {16'd0, q[0].m});
                chk("frame_err_invalid", {31'd0, bus.err_invalid}, {31'd0, q[0].inv});
                chk("frame_err_blank", {31'd0, bus.err_blank}, {31'd0, q[0].blank});
                if (bus.out_ready && ena) void'(q.pop_front());
            end
        end else begin
            chk("held_matrix", {16'd0, bus.matrix_c}, {16'd0, last_m});
            chk("held_err_invalid", {31'd0, bus.err_invalid}, {31'd0, last_inv});
            chk("held_err_blank", {31'd0, bus.err_blank}, {31'd0, last_blank});
        end
    end

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        bus.seg_in = 7'h00;
        bus.digit_sel = 2'd0;
        bus.seg_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        chk("reset_seg_ready", {31'd0, bus.seg_ready}, 32'd1);
        chk("reset_matrix", {16'd0, bus.matrix_c}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full frame, consumer ready
        beat(2'd0, 7'h5B);
        beat(2'd1, 7'h66);
        beat(2'd2, 7'h06);
        beat(2'd3, 7'h7F);
        chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("full_matrix", {16'd0, bus.matrix_c}, 32'h4281);
        tick();
        chk("full_valid_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        chk("full_cnt", {24'd0, bus.frame_cnt}, 32'd1);

        // Backpressure with extra beats ignored
        bus.out_ready = 1'b0;
        beat(2'd0, 7'h5B);
        beat(2'd1, 7'h66);
        beat(2'd2, 7'h06);
        beat(2'd3, 7'h7F);
        for (int i = 0; i < 5; i++) begin
            bus.seg_valid = 1'b1;
            bus.digit_sel = 2'(i);
            bus.seg_in = 7'h3F;
            tick();
        end
        bus.seg_valid = 1'b0;
        chk("bp_matrix", {16'd0, bus.matrix_c}, 32'h4281);
        bus.out_ready = 1'b1;
        tick();

        // Error marks
        beat(2'd0, 7'h00);
        beat(2'd1, 7'h3F);
        beat(2'd2, 7'h12);
        beat(2'd3, 7'h07);
        chk("err_matrix", {16'd0, bus.matrix_c}, 32'h0F70);
        chk("err_blank", {31'd0, bus.err_blank}, 32'd1);
        chk("err_invalid", {31'd0, bus.err_invalid}, 32'd1);
        tick();

        // Overwrite of a staged digit
        beat(2'd0, 7'h06);
        beat(2'd0, 7'h4F);
        beat(2'd1, 7'h3F);
        beat(2'd2, 7'h3F);
        beat(2'd3, 7'h3F);
        chk("overwrite_elem1", {28'd0, bus.matrix_c[11:8]}, 32'd3);
        tick();

        // Flush together with the fourth beat
        beat(2'd0, 7'h06);
        beat(2'd1, 7'h06);
        beat(2'd2, 7'h06);
        bus.flush = 1'b1;
        beat(2'd3, 7'h06);
        bus.flush = 1'b0;
        beat(2'd3, 7'h06);
        tick();
        chk("flush_no_frame", {31'd0, bus.out_valid}, 32'd0);
        beat(2'd0, 7'h07);
        beat(2'd1, 7'h07);
        beat(2'd2, 7'h07);
        chk("flush_needs_all", {31'd0, bus.out_valid}, 32'd1);
        tick();

        // Randomized traffic with enable, flush and backpressure
        for (int i = 0; i < 400; i++) begin
            bus.seg_valid = 1'($urandom_range(0, 1));
            bus.digit_sel = 2'($urandom_range(0, 3));
            bus.seg_in = rand_pat();
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            ena = ($urandom_range(0, 9) != 0);
            tick();
        end
        ena = 1'b1;
        bus.seg_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        // Reset while holding a frame
        bus.out_ready = 1'b0;
        beat(2'd0, 7'h7D);
        beat(2'd1, 7'h6D);
        beat(2'd2, 7'h4F);
        beat(2'd3, 7'h66);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_hold_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_hold_matrix", {16'd0, bus.matrix_c}, 32'h0);
        chk("rst_hold_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // 256 frames wrap the counter
        for (int f = 0; f < 256; f++) begin
            for (int d = 0; d < 4; d++) beat(2'(d), pats[$urandom_range(0, 8)]);
            tick();
        end
        chk("cnt_wrap", {24'd0, bus.frame_cnt}, 32'd0);

        tick();
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
